// File: rtl/fetch_gshare.sv
// Fetch stage with jal/branch predecode and a gshare predictor of 2-bit counters.
// The table is cleared to weakly-not-taken by a walk over every entry after reset.
`timescale 1ns/1ps
module fetch_gshare #(
  parameter logic [31:0] RESET_PC  = 32'h0,
  parameter int          HIST_BITS = 8
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 stall,
  input  logic                 flush,
  input  logic [31:0]          redirect_pc,
  input  logic [HIST_BITS-1:0] redirect_hist,
  input  logic                 upd_valid,
  input  logic [HIST_BITS-1:0] upd_index,
  input  logic                 upd_taken,
  output logic [31:0]          imem_addr,
  output logic                 imem_en,
  input  logic [31:0]          imem_data,
  input  logic [31:0]          imem_data1,
  output logic                 valid,
  output logic [31:0]          pc,
  output logic [31:0]          instr,
  output logic [31:0]          instr1,
  output logic                 prediction,
  output logic [HIST_BITS-1:0] pc_xor_global_history
);

  localparam int ENTRIES = 1 << HIST_BITS;

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t               r_state;
  state_t               w_state_next;
  logic [HIST_BITS-1:0] r_init_cnt;
  logic [31:0]          r_fetch_pc;
  logic [31:0]          r_f2_pc;
  logic                 r_f2_valid;
  logic [HIST_BITS-1:0] r_ghist;
  logic [1:0]           r_table [ENTRIES];

  logic                 w_run;
  logic [6:0]           w_opcode;
  logic                 w_is_jal;
  logic                 w_is_branch;
  logic [31:0]          w_j_imm;
  logic [31:0]          w_b_imm;
  logic [31:0]          w_target;
  logic [HIST_BITS-1:0] w_index;
  logic [1:0]           w_counter;
  logic                 w_prediction;
  logic [1:0]           w_upd_cur;
  logic [1:0]           w_upd_next;

  logic [31:0]          w_fetch_pc_next;
  logic [31:0]          w_f2_pc_next;
  logic                 w_f2_valid_next;
  logic [HIST_BITS-1:0] w_ghist_next;
  logic                 w_imem_en;

  assign w_run       = (r_state == ST_RUN);
  assign w_opcode    = imem_data[6:0];
  assign w_is_jal    = (w_opcode == 7'b1101111);
  assign w_is_branch = (w_opcode == 7'b1100011);
  assign w_j_imm     = {{12{imem_data[31]}}, imem_data[19:12], imem_data[20],
                        imem_data[30:21], 1'b0};
  assign w_b_imm     = {{20{imem_data[31]}}, imem_data[7], imem_data[30:25],
                        imem_data[11:8], 1'b0};
  assign w_target    = r_f2_pc + (w_is_jal ? w_j_imm : w_b_imm);
  assign w_index     = r_f2_pc[HIST_BITS+1:2] ^ r_ghist;
  assign w_counter   = r_table[w_index];
  assign w_prediction = w_is_jal | (w_is_branch & w_counter[1]);

  assign w_upd_cur  = r_table[upd_index];
  assign w_upd_next = upd_taken ? ((w_upd_cur == 2'b11) ? 2'b11 : w_upd_cur + 2'b01)
                                : ((w_upd_cur == 2'b00) ? 2'b00 : w_upd_cur - 2'b01);

  assign imem_addr             = r_fetch_pc;
  assign imem_en               = w_imem_en;
  assign valid                 = r_f2_valid & w_run;
  assign pc                    = r_f2_pc;
  assign instr                 = imem_data;
  assign instr1                = imem_data1;
  assign prediction            = w_prediction;
  assign pc_xor_global_history = w_index;

  // Flush beats stall; a predicted-taken word in F2 squashes the fetch already in flight.
  always_comb begin
    w_state_next    = r_state;
    w_fetch_pc_next = r_fetch_pc;
    w_f2_pc_next    = r_f2_pc;
    w_f2_valid_next = r_f2_valid;
    w_ghist_next    = r_ghist;
    w_imem_en       = 1'b0;
    case (r_state)
      ST_INIT: begin
        if (&r_init_cnt) begin
          w_state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        if (flush) begin
          w_fetch_pc_next = redirect_pc;
          w_ghist_next    = redirect_hist;
          w_f2_valid_next = 1'b0;
        end else if (!stall) begin
          w_imem_en = 1'b1;
          if (r_f2_valid && w_is_branch) begin
            w_ghist_next = {r_ghist[HIST_BITS-2:0], w_prediction};
          end
          if (r_f2_valid && w_prediction) begin
            w_fetch_pc_next = w_target;
            w_f2_valid_next = 1'b0;
          end else begin
            w_f2_pc_next    = r_fetch_pc;
            w_f2_valid_next = 1'b1;
            w_fetch_pc_next = r_fetch_pc + 32'd4;
          end
        end
      end
      default: w_state_next = ST_INIT;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state    <= ST_INIT;
      r_init_cnt <= '0;
      r_fetch_pc <= RESET_PC;
      r_f2_pc    <= RESET_PC;
      r_f2_valid <= 1'b0;
      r_ghist    <= '0;
    end else begin
      r_state    <= w_state_next;
      r_init_cnt <= (r_state == ST_INIT) ? r_init_cnt + HIST_BITS'(1) : '0;
      r_fetch_pc <= w_fetch_pc_next;
      r_f2_pc    <= w_f2_pc_next;
      r_f2_valid <= w_f2_valid_next;
      r_ghist    <= w_ghist_next;
    end
  end

  // Table is cleared by the INIT walk rather than by reset, so it needs no reset term.
  always_ff @(posedge clk) begin
    if (r_state == ST_INIT) begin
      r_table[r_init_cnt] <= 2'b01;
    end else if (upd_valid) begin
      r_table[upd_index] <= w_upd_next;
    end
  end

endmodule

// File: tb/tb_fetch_gshare.sv
// Directed bench for fetch_gshare: stimulus pushes expected decode outputs into a
// queue, and an independent monitor pops and compares each accepted output.
`timescale 1ns/1ps
module tb_fetch_gshare;

  localparam int HB = 8;

  logic          clk = 1'b0;
  logic          rstn;
  logic          stall;
  logic          flush;
  logic [31:0]   redirect_pc;
  logic [HB-1:0] redirect_hist;
  logic          upd_valid;
  logic [HB-1:0] upd_index;
  logic          upd_taken;
  logic [31:0]   imem_addr;
  logic          imem_en;
  logic [31:0]   imem_data;
  logic [31:0]   imem_data1;
  logic          valid;
  logic [31:0]   pc;
  logic [31:0]   instr;
  logic [31:0]   instr1;
  logic          prediction;
  logic [HB-1:0] pc_xor_global_history;

  logic [31:0] mem [1024];

  typedef struct packed {
    logic [31:0]   pc;
    logic [31:0]   instr;
    logic [31:0]   instr1;
    logic          pred;
    logic [HB-1:0] idx;
  } exp_t;

  exp_t sbq[$];
  int   nCompared   = 0;
  int   nMismatched = 0;

  always #5 clk = ~clk;

  fetch_gshare #(.RESET_PC(32'h0), .HIST_BITS(HB)) dut (
    .clk(clk), .rstn(rstn), .stall(stall), .flush(flush),
    .redirect_pc(redirect_pc), .redirect_hist(redirect_hist),
    .upd_valid(upd_valid), .upd_index(upd_index), .upd_taken(upd_taken),
    .imem_addr(imem_addr), .imem_en(imem_en),
    .imem_data(imem_data), .imem_data1(imem_data1),
    .valid(valid), .pc(pc), .instr(instr), .instr1(instr1),
    .prediction(prediction), .pc_xor_global_history(pc_xor_global_history)
  );

  // Synchronous dual-port instruction memory with one cycle of read latency.
  always @(posedge clk) begin
    if (imem_en) begin
      imem_data  <= mem[imem_addr[11:2]];
      imem_data1 <= mem[imem_addr[11:2] + 10'd1];
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic pushExp(input logic [31:0] p, input logic pr, input logic [HB-1:0] ix);
    exp_t e;
    logic [9:0] w;
    w        = p[11:2] + 10'd1;
    e.pc     = p;
    e.instr  = mem[p[11:2]];
    e.instr1 = mem[w];
    e.pred   = pr;
    e.idx    = ix;
    sbq.push_back(e);
  endtask

  // One cycle: drive inputs just after the rising edge, return at the falling edge.
  task automatic applyStimulus(input logic s, input logic f, input logic [31:0] rpc,
                               input logic [HB-1:0] rh, input logic uv,
                               input logic [HB-1:0] ui, input logic ut);
    @(posedge clk);
    #1;
    stall = s; flush = f; redirect_pc = rpc; redirect_hist = rh;
    upd_valid = uv; upd_index = ui; upd_taken = ut;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(1'b0, 1'b0, 32'h0, '0, 1'b0, '0, 1'b0);
  endtask

  // Release reset, expect 256 quiet cycles of table init, then the first RUN cycle.
  task automatic runInit();
    int bad;
    bad = 0;
    @(posedge clk);
    #1;
    rstn = 1'b1;
    stall = 1'b0; flush = 1'b0; upd_valid = 1'b0;
    @(negedge clk);
    if (valid !== 1'b0 || imem_en !== 1'b0) bad++;
    repeat (255) begin
      idle(1);
      if (valid !== 1'b0 || imem_en !== 1'b0) bad++;
    end
    checkOutput("init_quiet_cycles", 32'(bad), 32'd0);
    idle(1);
    checkOutput("run_first_en", 32'(imem_en), 32'd1);
    checkOutput("run_first_addr", imem_addr, 32'h0);
    checkOutput("run_first_valid", 32'(valid), 32'd0);
  endtask

  // Monitor: an output is consumed whenever it is valid and neither stalled nor flushed.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rstn === 1'b1 && valid === 1'b1 && stall === 1'b0 && flush === 1'b0) begin
        nCompared++;
        if (sbq.size() == 0) begin
          nMismatched++;
          $display("[TB] FAIL unexpected_output: got pc=%h with no expected entry", pc);
        end else begin
          e = sbq.pop_front();
          if ({pc, instr, instr1, prediction, pc_xor_global_history} !== e) begin
            nMismatched++;
            $display("[TB] FAIL decode_output: got pc=%h instr=%h instr1=%h pred=%0d idx=%h expected pc=%h instr=%h instr1=%h pred=%0d idx=%h",
                     pc, instr, instr1, prediction, pc_xor_global_history,
                     e.pc, e.instr, e.instr1, e.pred, e.idx);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'h00000013 | (32'(i) << 20);
    mem[4]  = 32'h0400006F;  // 0x10: jal x0, +0x40
    mem[8]  = 32'h10000063;  // 0x20: beq x0, x0, +0x100
    mem[48] = 32'h04000063;  // 0xC0: beq x0, x0, +0x40

    rstn = 1'b0; stall = 1'b0; flush = 1'b0; redirect_pc = '0; redirect_hist = '0;
    upd_valid = 1'b0; upd_index = '0; upd_taken = 1'b0;
    @(negedge clk);
    checkOutput("reset_valid", 32'(valid), 32'd0);
    checkOutput("reset_en", 32'(imem_en), 32'd0);
    checkOutput("reset_addr", imem_addr, 32'h0);

    runInit();

    // Sequential stream into the jal; target 0x50 after one bubble, ghist untouched.
    pushExp(32'h00, 1'b0, 8'h00); pushExp(32'h04, 1'b0, 8'h01);
    pushExp(32'h08, 1'b0, 8'h02); pushExp(32'h0C, 1'b0, 8'h03);
    pushExp(32'h10, 1'b1, 8'h04); pushExp(32'h50, 1'b0, 8'h14);
    pushExp(32'h54, 1'b0, 8'h15);
    idle(5);
    idle(1);
    checkOutput("jal_bubble_valid", 32'(valid), 32'd0);
    checkOutput("jal_target_addr", imem_addr, 32'h50);
    idle(2);

    // Redirect to the beq; fresh counter predicts not-taken.
    applyStimulus(1'b0, 1'b1, 32'h20, 8'h00, 1'b0, '0, 1'b0);
    idle(1);
    checkOutput("flush_addr", imem_addr, 32'h20);
    checkOutput("flush_valid", 32'(valid), 32'd0);
    pushExp(32'h20, 1'b0, 8'h08); pushExp(32'h24, 1'b0, 8'h09);
    pushExp(32'h28, 1'b0, 8'h0A);
    idle(3);

    // Train index 0x08 to strongly taken while stalled, then refetch the beq.
    applyStimulus(1'b1, 1'b0, 32'h0, 8'h00, 1'b1, 8'h08, 1'b1);
    applyStimulus(1'b1, 1'b0, 32'h0, 8'h00, 1'b1, 8'h08, 1'b1);
    applyStimulus(1'b0, 1'b1, 32'h20, 8'h00, 1'b0, '0, 1'b0);
    pushExp(32'h20, 1'b1, 8'h08); pushExp(32'h120, 1'b0, 8'h49);
    pushExp(32'h124, 1'b0, 8'h48);
    idle(2);
    idle(1);
    checkOutput("beq_bubble_valid", 32'(valid), 32'd0);
    checkOutput("beq_target_addr", imem_addr, 32'h120);
    idle(2);

    // Three stalled cycles with 0x128 held at the output.
    repeat (3) begin
      applyStimulus(1'b1, 1'b0, 32'h0, 8'h00, 1'b0, '0, 1'b0);
      checkOutput("stall_en", 32'(imem_en), 32'd0);
      checkOutput("stall_valid", 32'(valid), 32'd1);
      checkOutput("stall_pc", pc, 32'h128);
      checkOutput("stall_instr", instr, mem[74]);
    end
    pushExp(32'h128, 1'b0, 8'h4B); pushExp(32'h12C, 1'b0, 8'h4A);
    pushExp(32'h130, 1'b0, 8'h4D);
    idle(3);

    // Flush overriding stall, with repaired history 0xA5.
    applyStimulus(1'b1, 1'b1, 32'h200, 8'hA5, 1'b0, '0, 1'b0);
    idle(1);
    checkOutput("flush_stall_addr", imem_addr, 32'h200);
    checkOutput("flush_stall_valid", 32'(valid), 32'd0);
    pushExp(32'h200, 1'b0, 8'h25); pushExp(32'h204, 1'b0, 8'h24);
    idle(1);
    checkOutput("redirect_valid", 32'(valid), 32'd1);
    checkOutput("redirect_pc", pc, 32'h200);
    checkOutput("redirect_index", 32'(pc_xor_global_history), 32'h25);
    idle(1);

    // Saturation: 0x30 goes 01->00->00->00->01; 0x08 goes 11->11->10->01.
    repeat (3) applyStimulus(1'b1, 1'b0, 32'h0, 8'h00, 1'b1, 8'h30, 1'b0);
    applyStimulus(1'b1, 1'b0, 32'h0, 8'h00, 1'b1, 8'h30, 1'b1);
    applyStimulus(1'b1, 1'b0, 32'h0, 8'h00, 1'b1, 8'h08, 1'b1);
    repeat (2) applyStimulus(1'b1, 1'b0, 32'h0, 8'h00, 1'b1, 8'h08, 1'b0);
    applyStimulus(1'b0, 1'b1, 32'hC0, 8'h00, 1'b0, '0, 1'b0);
    pushExp(32'hC0, 1'b0, 8'h30); pushExp(32'hC4, 1'b0, 8'h31);
    idle(3);
    applyStimulus(1'b0, 1'b1, 32'h20, 8'h00, 1'b0, '0, 1'b0);
    pushExp(32'h20, 1'b0, 8'h08); pushExp(32'h24, 1'b0, 8'h09);
    idle(3);

    // One more taken update on 0x30 (01->10) flips the 0xC0 branch to taken.
    applyStimulus(1'b1, 1'b0, 32'h0, 8'h00, 1'b1, 8'h30, 1'b1);
    applyStimulus(1'b0, 1'b1, 32'hC0, 8'h00, 1'b0, '0, 1'b0);
    pushExp(32'hC0, 1'b1, 8'h30); pushExp(32'h100, 1'b0, 8'h41);
    pushExp(32'h104, 1'b0, 8'h40);
    idle(5);

    // Asynchronous reset mid-cycle, then the whole init walk again.
    @(posedge clk);
    #3;
    rstn = 1'b0;
    #1;
    checkOutput("async_reset_valid", 32'(valid), 32'd0);
    checkOutput("async_reset_en", 32'(imem_en), 32'd0);
    checkOutput("async_reset_addr", imem_addr, 32'h0);
    pushExp(32'h00, 1'b0, 8'h00); pushExp(32'h04, 1'b0, 8'h01);
    pushExp(32'h08, 1'b0, 8'h02);
    runInit();
    idle(3);
    repeat (3) applyStimulus(1'b1, 1'b0, 32'h0, 8'h00, 1'b0, '0, 1'b0);
    checkOutput("scoreboard_drained", 32'(sbq.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
